// File: rtl/dotprod.sv
// dotprod: Q16.16 dot-product engine with a CPU slave port and a memory master port.
// Optional feature macro DOTPROD_RELU_EN clamps negative results to zero.
module dotprod (
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  output logic [31:0] slave_readdata,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  output logic        master_write,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic [31:0] master_writedata
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    RD_W   = 4'd1,
    WAIT_W = 4'd2,
    RD_A   = 4'd3,
    WAIT_A = 4'd4,
    MAC    = 4'd5,
    BIAS   = 4'd6,
    WR     = 4'd7,
    DONE   = 4'd8
  } state_t;

  state_t      state_r;
  logic [31:0] dst_r, wbase_r, abase_r, bias_r, len_r;
  logic [31:0] w_r, a_r, acc_r, idx_r, wptr_r, aptr_r;
  logic [31:0] result_r, readback_r;

  logic [63:0] w_ext_s, a_ext_s, prod_s;
  logic [31:0] mac_term_s, idx_next_s, sum_s, result_s;
  logic        cpu_access_s;
  logic        unused_prod_s;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign w_ext_s       = {{32{w_r[31]}}, w_r};
  assign a_ext_s       = {{32{a_r[31]}}, a_r};
  assign prod_s        = w_ext_s * a_ext_s;
  assign mac_term_s    = prod_s[47:16];
  assign unused_prod_s = ^{prod_s[63:48], prod_s[15:0]};
  assign idx_next_s    = idx_r + 32'd1;
  assign cpu_access_s  = (state_r == IDLE) && !slave_waitrequest;

  // Final result: accumulator plus bias, optionally clamped at zero.
  always_comb begin
    sum_s = acc_r + bias_r;
`ifdef DOTPROD_RELU_EN
    if (sum_s[31]) begin
      result_s = 32'd0;
    end else begin
      result_s = sum_s;
    end
`else
    result_s = sum_s;
`endif
  end

  // Control FSM, datapath registers and all registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= IDLE;
      slave_waitrequest <= 1'b1;
      slave_readdata    <= 32'd0;
      master_address    <= 32'd0;
      master_writedata  <= 32'd0;
      master_read       <= 1'b0;
      master_write      <= 1'b0;
      dst_r             <= 32'd0;
      wbase_r           <= 32'd0;
      abase_r           <= 32'd0;
      bias_r            <= 32'd0;
      len_r             <= 32'd0;
      w_r               <= 32'd0;
      a_r               <= 32'd0;
      acc_r             <= 32'd0;
      idx_r             <= 32'd0;
      wptr_r            <= 32'd0;
      aptr_r            <= 32'd0;
      result_r          <= 32'd0;
      readback_r        <= 32'd0;
    end else begin
      slave_readdata <= 32'd0;
      case (state_r)
        IDLE: begin
          slave_waitrequest <= 1'b0;
          if (cpu_access_s && slave_read && (slave_address == 4'd0)) begin
            slave_readdata <= readback_r;
          end
          if (cpu_access_s && slave_write) begin
            case (slave_address)
              4'd0: begin
                slave_waitrequest <= 1'b1;
                acc_r             <= 32'd0;
                idx_r             <= 32'd0;
                wptr_r            <= wbase_r;
                aptr_r            <= abase_r;
                if (len_r == 32'd0) begin
                  state_r <= BIAS;
                end else begin
                  state_r        <= RD_W;
                  master_address <= wbase_r;
                  master_read    <= 1'b1;
                end
              end
              4'd1:    dst_r   <= slave_writedata;
              4'd2:    wbase_r <= slave_writedata;
              4'd3:    abase_r <= slave_writedata;
              4'd4:    bias_r  <= slave_writedata;
              4'd5:    len_r   <= slave_writedata;
              default: ;
            endcase
          end
        end
        RD_W: begin
          if (!master_waitrequest) begin
            master_read <= 1'b0;
            state_r     <= WAIT_W;
          end
        end
        WAIT_W: begin
          if (master_readdatavalid) begin
            w_r            <= master_readdata;
            master_address <= aptr_r;
            master_read    <= 1'b1;
            state_r        <= RD_A;
          end
        end
        RD_A: begin
          if (!master_waitrequest) begin
            master_read <= 1'b0;
            state_r     <= WAIT_A;
          end
        end
        WAIT_A: begin
          if (master_readdatavalid) begin
            a_r     <= master_readdata;
            state_r <= MAC;
          end
        end
        MAC: begin
          acc_r  <= acc_r + mac_term_s;
          idx_r  <= idx_next_s;
          wptr_r <= wptr_r + 32'd4;
          aptr_r <= aptr_r + 32'd4;
          if (idx_next_s == len_r) begin
            state_r <= BIAS;
          end else begin
            master_address <= wptr_r + 32'd4;
            master_read    <= 1'b1;
            state_r        <= RD_W;
          end
        end
        BIAS: begin
          result_r         <= result_s;
          master_address   <= dst_r;
          master_writedata <= result_s;
          master_write     <= 1'b1;
          state_r          <= WR;
        end
        WR: begin
          if (!master_waitrequest) begin
            master_write <= 1'b0;
            state_r      <= DONE;
          end
        end
        DONE: begin
          readback_r        <= result_r;
          slave_waitrequest <= 1'b0;
          state_r           <= IDLE;
        end
        default: begin
          master_read  <= 1'b0;
          master_write <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dotprod.sv
// Self-checking bench for dotprod: vector table, corner sequences and a randomized
// run against an arithmetic reference model; memory is a stalling bus responder.
`timescale 1ns/1ps
module tb_dotprod;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slave_waitrequest;
  logic [3:0]  slave_address = 4'd0;
  logic        slave_read = 1'b0;
  logic        slave_write = 1'b0;
  logic [31:0] slave_readdata;
  logic [31:0] slave_writedata = 32'd0;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic        master_write;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic [31:0] master_writedata;

  dotprod dut (
    .clk(clk), .rst(rst),
    .slave_waitrequest(slave_waitrequest), .slave_address(slave_address),
    .slave_read(slave_read), .slave_write(slave_write),
    .slave_readdata(slave_readdata), .slave_writedata(slave_writedata),
    .master_waitrequest(master_waitrequest), .master_address(master_address),
    .master_read(master_read), .master_write(master_write),
    .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
    .master_writedata(master_writedata)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] DST = 32'h0000_0040;
  localparam logic [31:0] WB  = 32'h0000_0100;
  localparam logic [31:0] AB  = 32'h0000_0200;

  logic [31:0] tbw [0:15];
  logic [31:0] tba [0:15];
  int   stall_cycles = 0;
  int   rd_latency = 0;
  logic noise_en = 1'b0;

  // Responder state, written only by the responder process.
  int          stall_cnt = 0;
  int          rd_count = 0;
  int          wr_count = 0;
  int          proto_err = 0;
  logic        pend = 1'b0;
  int          pend_timer = 0;
  logic [31:0] pend_data = 32'd0;
  logic        noise_r = 1'b0;
  logic [31:0] last_waddr = 32'd0;
  logic [31:0] last_wdata = 32'd0;
  logic        stalled_prev = 1'b0;
  logic        rst_prev = 1'b0;
  logic [31:0] saved_addr = 32'd0;
  logic [31:0] saved_wdata = 32'd0;
  logic        saved_rd = 1'b0;
  logic        saved_wr = 1'b0;

  int checks = 0;
  int fails = 0;

  assign master_waitrequest   = (master_read || master_write) && (stall_cnt < stall_cycles);
  assign master_readdatavalid = (pend && pend_timer == 0) || noise_r;
  assign master_readdata      = (pend && pend_timer == 0) ? pend_data : 32'hBAD0_BAD0;

  function automatic logic [31:0] mem_lookup(input logic [31:0] addr);
    if (addr >= WB && addr < WB + 32'd64) return tbw[(addr - WB) >> 2];
    if (addr >= AB && addr < AB + 32'd64) return tba[(addr - AB) >> 2];
    return 32'hDEAD_BEEF;
  endfunction

  // Bus responder: stalls, delayed read data, stray valids, protocol monitor.
  always @(posedge clk) begin
    logic req, acc_rd, bad;
    req    = master_read || master_write;
    acc_rd = master_read && !master_waitrequest;
    bad    = master_read && master_write;
    if (stalled_prev && !rst_prev &&
        (master_address != saved_addr || master_read != saved_rd ||
         master_write != saved_wr || master_writedata != saved_wdata)) bad = 1'b1;
    if (bad) proto_err <= proto_err + 1;
    stall_cnt <= (req && master_waitrequest) ? stall_cnt + 1 : 0;
    if (acc_rd) begin
      rd_count   <= rd_count + 1;
      pend       <= 1'b1;
      pend_timer <= rd_latency;
      pend_data  <= mem_lookup(master_address);
    end else if (pend) begin
      if (pend_timer == 0) pend <= 1'b0;
      else pend_timer <= pend_timer - 1;
    end
    noise_r <= noise_en && !pend && !acc_rd && ($urandom_range(0, 3) == 0);
    if (master_write && !master_waitrequest) begin
      wr_count   <= wr_count + 1;
      last_waddr <= master_address;
      last_wdata <= master_writedata;
    end
    stalled_prev <= req && master_waitrequest;
    rst_prev     <= rst;
    saved_addr   <= master_address;
    saved_wdata  <= master_writedata;
    saved_rd     <= master_read;
    saved_wr     <= master_write;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic slave_acc(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                           output logic [31:0] rdata, output int waited);
    slave_address   = addr;
    slave_write     = wr;
    slave_read      = !wr;
    slave_writedata = data;
    waited = 0;
    while (slave_waitrequest && waited < 3000) begin
      tick();
      waited++;
    end
    if (slave_waitrequest) check("slave_timeout", 32'd1, 32'd0);
    tick();
    rdata       = slave_readdata;
    slave_write = 1'b0;
    slave_read  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (slave_waitrequest && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_idle"}, {31'd0, slave_waitrequest}, 32'd0);
  endtask

  task automatic cfg_and_start(input int len, input logic [31:0] bias);
    logic [31:0] d;
    int w;
    slave_acc(1'b1, 4'd1, DST, d, w);
    slave_acc(1'b1, 4'd2, WB, d, w);
    slave_acc(1'b1, 4'd3, AB, d, w);
    slave_acc(1'b1, 4'd4, bias, d, w);
    slave_acc(1'b1, 4'd5, 32'(len), d, w);
    slave_acc(1'b1, 4'd0, 32'd0, d, w);
  endtask

  task automatic run(input string name, input int len, input logic [31:0] bias,
                     input logic [31:0] exp);
    int rd0, wr0, pe0, w;
    logic [31:0] d;
    rd0 = rd_count; wr0 = wr_count; pe0 = proto_err;
    cfg_and_start(len, bias);
    wait_idle(name);
    check({name, "_wdata"}, last_wdata, exp);
    check({name, "_waddr"}, last_waddr, DST);
    check({name, "_nwrites"}, 32'(wr_count - wr0), 32'd1);
    check({name, "_nreads"}, 32'(rd_count - rd0), 32'(2 * len));
    check({name, "_protocol"}, 32'(proto_err - pe0), 32'd0);
    slave_acc(1'b0, 4'd0, 32'd0, d, w);
    check({name, "_readback"}, d, exp);
  endtask

  // Reference: sum of floor(w*a / 2^16) over the vector, plus bias, mod 2^32.
  function automatic logic [31:0] model(input int len, input logic [31:0] bias);
    longint acc = 0;
    logic [31:0] r;
    for (int i = 0; i < len; i++)
      acc += (longint'($signed(tbw[i])) * longint'($signed(tba[i]))) >>> 16;
    r = 32'(acc) + bias;
`ifdef DOTPROD_RELU_EN
    if ($signed(r) < 0) r = 32'd0;
`endif
    return r;
  endfunction

  typedef struct {
    string           name;
    int              len;
    logic [3:0][31:0] w;
    logic [3:0][31:0] a;
    logic [31:0]     bias;
    int              stalls;
    int              lat;
    logic [31:0]     exp;
  } vec_t;

  initial begin
    vec_t vt [5];
    logic [31:0] d;
    int w, n, rd0, wr0, len;
    logic [31:0] bias;

    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt [5];
    logic [31:0] d, bias;
    int w, n, rd0, wr0, len;

    // element [0] is the rightmost word of each packed list
    vt[0] = '{"dot3", 3, {32'd0, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000},
              {32'd0, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000}, 32'd0, 0, 0, 32'h0006_0000};
    vt[1] = '{"len0", 0, {32'd0, 32'd0, 32'd0, 32'd0}, {32'd0, 32'd0, 32'd0, 32'd0},
              32'h0005_0000, 1, 0, 32'h0005_0000};
`ifdef DOTPROD_RELU_EN
    vt[2] = '{"neg", 1, {32'd0, 32'd0, 32'd0, 32'hFFFF_0000}, {32'd0, 32'd0, 32'd0, 32'h0002_0000},
              32'd0, 0, 1, 32'h0000_0000};
`else
    vt[2] = '{"neg", 1, {32'd0, 32'd0, 32'd0, 32'hFFFF_0000}, {32'd0, 32'd0, 32'd0, 32'h0002_0000},
              32'd0, 0, 1, 32'hFFFE_0000};
`endif
    vt[3] = '{"stall5", 3, {32'd0, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000},
              {32'd0, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000}, 32'd0, 5, 3, 32'h0006_0000};
    vt[4] = '{"mixed", 2, {32'd0, 32'd0, 32'h0001_8000, 32'h0000_8000},
              {32'd0, 32'd0, 32'hFFFE_0000, 32'h0004_0000}, 32'h0001_0000, 2, 2, 32'h0000_0000};

    tick();
    tick();
    check("rst_waitreq", {31'd0, slave_waitrequest}, 32'd1);
    check("rst_mread", {31'd0, master_read}, 32'd0);
    check("rst_mwrite", {31'd0, master_write}, 32'd0);
    check("rst_maddr", master_address, 32'd0);
    check("rst_rdata", slave_readdata, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_waitreq", {31'd0, slave_waitrequest}, 32'd0);
    slave_acc(1'b0, 4'd0, 32'd0, d, w);
    check("rst_readback", d, 32'd0);

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) begin
        tbw[j] = vt[i].w[j];
        tba[j] = vt[i].a[j];
      end
      stall_cycles = vt[i].stalls;
      rd_latency   = vt[i].lat;
      noise_en     = (i % 2 == 1);
      run(vt[i].name, vt[i].len, vt[i].bias, vt[i].exp);
    end
    slave_acc(1'b0, 4'd5, 32'd0, d, w);
    check("read_other_offset", d, 32'd0);

    // Reset while waiting for element 2's activation: nothing may be written.
    for (int j = 0; j < 4; j++) begin
      tbw[j] = vt[0].w[j];
      tba[j] = vt[0].a[j];
    end
    stall_cycles = 0; rd_latency = 5; noise_en = 1'b0;
    rd0 = rd_count; wr0 = wr_count;
    cfg_and_start(3, 32'd0);
    n = 0;
    while (rd_count - rd0 < 4 && n < 300) begin
      tick();
      n++;
    end
    check("abort_reached_wait_a", 32'(rd_count - rd0), 32'd4);
    tick();
    rst = 1'b1;
    tick();
    check("abort_rst_waitreq", {31'd0, slave_waitrequest}, 32'd1);
    rst = 1'b0;
    tick();
    check("abort_idle_waitreq", {31'd0, slave_waitrequest}, 32'd0);
    repeat (10) tick();
    check("abort_no_write", 32'(wr_count - wr0), 32'd0);
    slave_acc(1'b0, 4'd0, 32'd0, d, w);
    check("abort_readback", d, 32'd0);
    // Cleared config: a bare start writes 0+0 to address 0.
    slave_acc(1'b1, 4'd0, 32'd0, d, w);
    wait_idle("abort_bare");
    check("abort_cfg_addr", last_waddr, 32'd0);
    check("abort_cfg_data", last_wdata, 32'd0);
    rd_latency = 1;
    run("after_abort", 3, 32'd0, 32'h0006_0000);

    // Bias write during a busy run is stalled and only affects later runs.
    stall_cycles = 2;
    cfg_and_start(3, 32'd0);
    slave_acc(1'b1, 4'd4, 32'h0007_0000, d, w);
    check("busy_write_stalled", {31'd0, (w > 10)}, 32'd1);
    check("busy_bias_unchanged", last_wdata, 32'h0006_0000);
    slave_acc(1'b1, 4'd5, 32'd0, d, w);
    slave_acc(1'b1, 4'd0, 32'd0, d, w);
    wait_idle("busy_followup");
    check("busy_bias_applied_later", last_wdata, 32'h0007_0000);

    // Randomized vectors against the reference model.
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 8);
      for (int j = 0; j < 16; j++) begin
        tbw[j] = $urandom;
        tba[j] = $urandom;
      end
      bias = $urandom;
      stall_cycles = $urandom_range(0, 3);
      rd_latency   = $urandom_range(0, 3);
      noise_en     = 1'b1;
      run($sformatf("rand%0d", r), len, bias, model(len, bias));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dotprod.md
DOTPROD -- requirements
Module: dotprod

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state changes on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: slave_waitrequest  out  1  CPU stall while busy.
REQ-004 SHALL have: slave_address  in  4  word offset; slave_read, slave_write  in  1 each.
REQ-005 SHALL have: slave_readdata  out  32; slave_writedata  in  32.
REQ-006 SHALL have: master_waitrequest  in  1; master_address  out  32; master_read, master_write  out  1 each.
REQ-007 SHALL have: master_readdata  in  32; master_readdatavalid  in  1; master_writedata  out  32.

Function
REQ-008 SHALL decode these CPU write offsets in IDLE: 1 = dst address, 2 = weight base, 3 = activation base, 4 = bias, 5 = length (words); 0 = start.
REQ-009 SHALL hold config registers between runs; only CPU writes modify them.
REQ-010 SHALL return the last result on slave_readdata for a read of offset 0 while in IDLE, and 0 for any other offset.
REQ-011 SHALL drive slave_waitrequest low in IDLE and high from the cycle after start until the return to IDLE; CPU accesses during busy are stalled and never decoded.
REQ-012 SHALL use states IDLE, RD_W, WAIT_W, RD_A, WAIT_A, MAC, BIAS, WR, DONE.
REQ-013 SHALL on start: load acc=0, idx=0, wptr=weight base, aptr=activation base; go to BIAS if length==0, else RD_W.
REQ-014 RD_W/RD_A SHALL drive master_address=wptr/aptr with master_read=1, holding both until a cycle with master_waitrequest=0, then drop read and go to WAIT_W/WAIT_A.
REQ-015 WAIT_W/WAIT_A SHALL capture master_readdata on the first cycle with master_readdatavalid=1 into w/a, then go to RD_A/MAC respectively.
REQ-016 MAC SHALL compute signed 32x32->64 product w*a, add product bits [47:16] (Q16.16) to acc, wrap mod 2^32, increment idx, and add 4 to wptr and aptr.
REQ-017 MAC SHALL go to BIAS if idx+1==length, else RD_W; length is unsigned 32-bit.
REQ-018 BIAS SHALL compute result=acc+bias, wrap mod 2^32, apply the REQ-025 option, then go to WR.
REQ-019 WR SHALL drive master_address=dst, master_writedata=result, master_write=1, held stable until master_waitrequest=0, then deassert and go to DONE.
REQ-020 DONE SHALL latch result into the readback register and go to IDLE next cycle.
REQ-021 SHALL never assert master_read and master_write together; outside RD_*/WR both are 0.
REQ-022 SHALL ignore master_readdatavalid outside WAIT_W/WAIT_A.

Reset
REQ-023 SHALL on rst=1 at a clock edge, including mid-run, enter IDLE and set slave_waitrequest=1 for that cycle (0 from the next IDLE cycle).
REQ-024 SHALL clear on reset: slave_readdata, master_address, master_writedata, config registers, acc and readback, all to 0; master_read and master_write to 0. An aborted run writes nothing.

Configuration
REQ-025 With macro DOTPROD_RELU_EN defined, BIAS SHALL clamp a negative result (bit31=1) to 0; without it, result passes unmodified.

Verification
REQ-026 weights {0x00010000,0x00020000,0x00030000}, acts {0x00010000,0x00010000,0x00010000}, bias 0, len 3 -> mem[dst]=0x00060000, offset-0 read 0x00060000.
REQ-027 len 0, bias 0x00050000 -> exactly one write, mem[dst]=0x00050000, no master reads.
REQ-028 weight 0xFFFF0000 (-1.0), act 0x00020000, bias 0, len 1 -> 0xFFFE0000 without DOTPROD_RELU_EN, 0x00000000 with it.
REQ-029 master_waitrequest high 5 cycles on every read/write, readdatavalid 3 cycles after acceptance -> same result as REQ-026; address and read/write stable while waitrequest=1.
REQ-030 rst pulse during WAIT_A of element 2 -> no master write; registers and readback read 0; a new run then completes correctly.
REQ-031 CPU write to offset 4 while busy -> stalled by slave_waitrequest; bias unchanged for the running computation.
